nor4_sweep_ctrl: RTL and testbench
==================================

Name: nor4_sweep_ctrl

Overview:
Self-checking sequencer for the four-input NOR datapath (four_nor).
- On `start`, drives all 16 input combinations onto inA..inD.
- Holds each combination for a programmable number of cycles, then samples outG.
- Compares the sample against the ideal NOR and reports mismatch count, first failing vector and pass/fail.
- Replaces free-running delay-toggled stimulus with a clocked, repeatable lab-bench controller.

Parameters:
HOLD_CYCLES, 4, cycles each vector is held; outG sampled on last hold cycle; legal range 2..255
CNT_W, 8, width of internal hold counter; must hold HOLD_CYCLES-1

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse/level; accepted only in IDLE
dut_out  input  1  outG from the NOR under control
vec_out  output  4  applied vector; bit3=inA, bit2=inB, bit1=inC, bit0=inD
busy  output  1  high while sweeping
done  output  1  one-cycle pulse at end of sweep
pass  output  1  high when last sweep had zero mismatches; held until next start
err_cnt  output  5  mismatch count of last/current sweep (0..16, no saturation needed)
first_fail_vec  output  4  vector of first mismatch
first_fail_valid  output  1  high once any mismatch recorded in current sweep

Behaviour:
- Reset (async assert, sync-free release): state=IDLE; vec_out=0, busy=0, done=0, pass=0, err_cnt=0, first_fail_vec=0, first_fail_valid=0, hold counter=0, index=0.
- States: IDLE, APPLY, DONE.
- IDLE: vec_out=0.
  - `start` high at an edge → APPLY.
  - Same edge: index=0, hold counter=0, err_cnt=0, first_fail_valid=0, first_fail_vec=0, pass=0.
  - Next cycle: busy=1, vec_out=seq(0).
- APPLY: vec_out=seq(index) stable for exactly HOLD_CYCLES cycles.
  - Hold counter increments each cycle.
  - On edge where counter==HOLD_CYCLES-1: sample dut_out; expected = (vec_out==4'b0000).
  - On mismatch: err_cnt+1; if first_fail_valid==0, capture first_fail_vec=vec_out and set first_fail_valid.
  - Same edge: counter=0, index+1.
  - Edge where index==15 is sampled → DONE.
- DONE (one cycle): busy=0, done=1, pass=(final err_cnt==0), vec_out returns to 0 → IDLE next edge.
- Latency: start accepted at edge E; busy high for 16*HOLD_CYCLES cycles; done high in cycle E+16*HOLD_CYCLES+1.
- `start` during APPLY/DONE is ignored; no restart or queueing. Start high in the IDLE cycle after DONE starts a new sweep.
- Reset mid-sweep: immediate return to reset values; partial results discarded.
- seq(i): binary i (default). Expected value is always computed from the applied vec_out, never from index.
- err_cnt and first_fail_* update live during the sweep. They hold after DONE until next accepted start.

Optional Feature:
NOR4_GRAY_SEQ_EN
- Defined: seq(i) = i ^ (i>>1), a Gray order where exactly one input changes between consecutive vectors. Sequence is 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8. Glitch-free transitions for lab timing observation.
- Undefined: binary order 0..15.
- All other timing and checking is identical.

Decomposition:
- Package/include nor4_sweep_pkg: state encoding (IDLE, APPLY, DONE), NUM_VEC=16, VEC_W=4, ERR_W=5, function seq_of(index) honouring NOR4_GRAY_SEQ_EN.
- One sub-module, nor4_hold_timer: counter with clear/enable and a `last` flag at HOLD_CYCLES-1.
- FSM, compare and result registers stay in top.

Test Plan:
1. Ideal NOR model on dut_out, HOLD_CYCLES=4, start pulse → busy 64 cycles; done at start+65; err_cnt=0, pass=1, first_fail_valid=0.
2. dut_out stuck 0 → err_cnt=1, first_fail_vec=4'b0000, pass=0.
3. dut_out stuck 1 → err_cnt=15, first_fail_vec=4'b0001 (both orders); dut_out = OR of inputs → err_cnt=16.
4. start re-pulsed at cycle 20 of sweep → ignored; single done at 65. rst_n low during vector 7 → all outputs 0 immediately, IDLE; new start gives clean 64-cycle sweep.
5. NOR4_GRAY_SEQ_EN defined → vec_out sequence 0,1,3,2,6,...,8. Hamming distance between consecutive vectors = 1. Ideal model still gives pass=1.
6. HOLD_CYCLES=2 with model delaying outG by 1 cycle → pass=1; same model with 2-cycle delay → err_cnt>0. Checks the sample point is the last hold cycle.

Source files
------------

// File: rtl/nor4_sweep_pkg.sv
// Shared types and helpers for the four-input NOR sweep controller.
// NOR4_GRAY_SEQ_EN selects Gray vector order instead of binary order.
package nor4_sweep_pkg;

    localparam int NUM_VEC = 16;
    localparam int VEC_W   = 4;
    localparam int ERR_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [VEC_W-1:0] seq_of(
        input logic [VEC_W-1:0] idx
    );
`ifdef NOR4_GRAY_SEQ_EN
        return idx ^ (idx >> 1);
`else
        return idx;
`endif
    endfunction

endpackage

// File: rtl/nor4_hold_timer.sv
// Per-vector hold counter: counts 0..HOLD_CYCLES-1 while enabled.
// Ports: clk_i, rst_ni, clr_i (sync clear), en_i (count), last_o (at HOLD-1).
module nor4_hold_timer
    import nor4_sweep_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last_o = (cnt_q == CNT_W'(HOLD_CYCLES - 1));

    // Wrap on the last hold cycle so the next vector starts at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nor4_sweep_ctrl.sv
// Sweeps all 16 vectors into a 4-input NOR, samples and checks outG.
// Ports: clk, rst_n, start, dut_out in; vec_out, busy, done, pass,
// err_cnt, first_fail_vec, first_fail_valid out. Macro NOR4_GRAY_SEQ_EN.
module nor4_sweep_ctrl
    import nor4_sweep_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dut_out,
    output logic [VEC_W-1:0] vec_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic             first_fail_valid
);

    state_t           state_q;
    logic [VEC_W-1:0] idx_q;
    logic [VEC_W-1:0] vec_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [ERR_W-1:0] err_q;
    logic [VEC_W-1:0] ffv_q;
    logic             ffok_q;

    logic start_acc;
    logic apply;
    logic last;
    logic exp_nor;
    logic mismatch;

    assign start_acc = (state_q == ST_IDLE) && start;
    assign apply     = (state_q == ST_APPLY);

    // Expected value comes from the vector actually driven, not the index.
    assign exp_nor   = (vec_q == '0);
    assign mismatch  = (dut_out != exp_nor);

    nor4_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (start_acc),
        .en_i   (apply),
        .last_o (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ffv_q   <= '0;
            ffok_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    vec_q <= '0;
                    if (start) begin
                        state_q <= ST_APPLY;
                        idx_q   <= '0;
                        vec_q   <= seq_of('0);
                        busy_q  <= 1'b1;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        ffv_q   <= '0;
                        ffok_q  <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    if (last) begin
                        if (mismatch) begin
                            err_q <= err_q + ERR_W'(1);
                            if (!ffok_q) begin
                                ffok_q <= 1'b1;
                                ffv_q  <= vec_q;
                            end
                        end
                        if (idx_q == VEC_W'(NUM_VEC - 1)) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            vec_q   <= '0;
                            pass_q  <= (err_q == '0) && !mismatch;
                        end else begin
                            idx_q <= idx_q + VEC_W'(1);
                            vec_q <= seq_of(idx_q + VEC_W'(1));
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign vec_out          = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_cnt          = err_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffok_q;

endmodule

// File: tb/tb_nor4_sweep_ctrl.sv
// Self-checking bench for nor4_sweep_ctrl (HOLD 4 and HOLD 2 instances).
// Honours NOR4_GRAY_SEQ_EN for the expected vector order.
module tb_nor4_sweep_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance A: HOLD_CYCLES=4, combinational models
    logic       start = 1'b0;
    logic       dut_out;
    logic [3:0] vec_out;
    logic       busy, done, pass, ffok;
    logic [4:0] err_cnt;
    logic [3:0] ffv;
    int         mode = 0;

    // instance B: HOLD_CYCLES=2, delayed ideal model
    logic       start2 = 1'b0;
    logic       dut_out2;
    logic [3:0] vec_out2;
    logic       busy2, done2, pass2, ffok2;
    logic [4:0] err_cnt2;
    logic [3:0] ffv2;
    logic       d1_q = 1'b1, d2_q = 1'b1;
    int         dly = 1;

    int n_chk = 0;
    int n_fail = 0;
    int ham_bad = 0;

    nor4_sweep_ctrl #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dut_out),
        .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_fail_vec(ffv), .first_fail_valid(ffok)
    );

    nor4_sweep_ctrl #(.HOLD_CYCLES(2), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .dut_out(dut_out2),
        .vec_out(vec_out2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err_cnt2), .first_fail_vec(ffv2), .first_fail_valid(ffok2)
    );

    // 0 ideal NOR, 1 stuck-0, 2 stuck-1, 3 OR
    always_comb begin
        dut_out = 1'b0;
        case (mode)
            0: dut_out = ~|vec_out;
            1: dut_out = 1'b0;
            2: dut_out = 1'b1;
            default: dut_out = |vec_out;
        endcase
    end

    always @(posedge clk) begin
        d1_q <= ~|vec_out2;
        d2_q <= d1_q;
    end
    assign dut_out2 = (dly == 1) ? d1_q : d2_q;

    function automatic logic [3:0] exp_seq(input int i);
        logic [3:0] b;
        b = 4'(i);
`ifdef NOR4_GRAY_SEQ_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_sweep(input int restart_at, output int done_k,
                             output int busy_n, output int done_n,
                             output int vec_bad);
        logic [3:0] prev;
        done_k = 0; busy_n = 0; done_n = 0; vec_bad = 0;
        prev = 4'd0;
        kick();
        for (int k = 1; k <= 140; k++) begin
            @(negedge clk);
            if (k == restart_at) start = 1'b1;
            if (k == restart_at + 1) start = 1'b0;
            if (busy) begin
                busy_n++;
                if (vec_out != exp_seq(((k - 1) / 4) % 16)) vec_bad++;
                if (k > 1 && (k - 1) % 4 == 0 &&
                    $countones(prev ^ vec_out) != 1) ham_bad++;
                prev = vec_out;
            end
            if (done) begin
                done_n++;
                if (done_k == 0) done_k = k;
            end
        end
    endtask

    typedef struct {
        string      nm;
        int         md;
        int         e_err;
        int         e_pass;
        logic [3:0] e_ffv;
        int         e_ffok;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int dk, bn, dn, vb;

        tbl[0] = '{"ideal",  0,  0, 1, 4'd0, 0};
        tbl[1] = '{"stuck0", 1,  1, 0, 4'd0, 1};
        tbl[2] = '{"stuck1", 2, 15, 0, 4'd1, 1};
        tbl[3] = '{"or",     3, 16, 0, 4'd0, 1};

        #12;
        chk("rst_vec",  vec_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err",  err_cnt, 0);
        chk("rst_ffok", ffok, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 4; r++) begin
            mode = tbl[r].md;
            run_sweep(0, dk, bn, dn, vb);
            chk({tbl[r].nm, "_donek"}, dk, 65);
            chk({tbl[r].nm, "_busyn"}, bn, 64);
            chk({tbl[r].nm, "_donen"}, dn, 1);
            chk({tbl[r].nm, "_vecs"},  vb, 0);
            chk({tbl[r].nm, "_err"},   err_cnt, tbl[r].e_err);
            chk({tbl[r].nm, "_pass"},  pass, tbl[r].e_pass);
            chk({tbl[r].nm, "_ffok"},  ffok, tbl[r].e_ffok);
            chk({tbl[r].nm, "_ffv"},   ffv, tbl[r].e_ffv);
            chk({tbl[r].nm, "_idle"},  vec_out, 0);
        end

        // restart pulse mid-sweep must be ignored
        mode = 0;
        run_sweep(20, dk, bn, dn, vb);
        chk("restart_donek", dk, 65);
        chk("restart_donen", dn, 1);
        chk("restart_busyn", bn, 64);
        chk("restart_pass",  pass, 1);

        // reset during vector 7 with a failing model
        mode = 1;
        kick();
        for (int k = 1; k <= 29; k++) @(negedge clk);
        chk("pre_rst_vec", vec_out, exp_seq(7));
        chk("pre_rst_err", err_cnt, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vec",  vec_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err",  err_cnt, 0);
        chk("mid_rst_ffok", ffok, 0);
        chk("mid_rst_ffv",  ffv, 0);
        chk("mid_rst_pass", pass, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        mode = 0;
        run_sweep(0, dk, bn, dn, vb);
        chk("post_rst_donek", dk, 65);
        chk("post_rst_busyn", bn, 64);
        chk("post_rst_vecs",  vb, 0);
        chk("post_rst_pass",  pass, 1);
        chk("post_rst_err",   err_cnt, 0);

`ifdef NOR4_GRAY_SEQ_EN
        chk("gray_hamming", ham_bad, 0);
`endif

        // sample point must be the last hold cycle
        for (int d = 1; d <= 2; d++) begin
            dly = d;
            dk = 0;
            repeat (3) @(negedge clk);
            @(negedge clk);
            start2 = 1'b1;
            @(posedge clk);
            #1 start2 = 1'b0;
            for (int k = 1; k <= 60; k++) begin
                @(negedge clk);
                if (done2 && dk == 0) dk = k;
            end
            chk($sformatf("h2_d%0d_donek", d), dk, 33);
            chk($sformatf("h2_d%0d_pass", d), pass2, d == 1 ? 1 : 0);
            chk($sformatf("h2_d%0d_err", d), err_cnt2, d == 1 ? 0 : 1);
            if (d == 2) chk("h2_d2_ffv", ffv2, exp_seq(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
